ro_freq_counter: RTL and testbench

//   Consumer stage for a ring oscillator: drives its enable, samples its free-running output
//   in the system clock domain and counts rising edges over a fixed gate window.

---
 rtl/ro_meas_pkg.sv | 31 +++
 rtl/ro_freq_counter_sync.sv | 28 ++
 rtl/ro_freq_counter.sv | 136 +++++++++++++
 tb/tb_ro_freq_counter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// Shared types and sizing helpers for the ring-oscillator frequency counter.
// Provides the measurement FSM state encoding and the timer width calculation.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_GATE   = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // Ceiling log2, never less than 1 so a degenerate timer still has a bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int tmr_width(input int gate_cycles, input int warmup_cycles);
        int m;
        m = (gate_cycles > warmup_cycles) ? gate_cycles : warmup_cycles;
        return clog2(m + 1);
    endfunction

endpackage

// File: rtl/ro_freq_counter_sync.sv
// Synchroniser for the asynchronous RO output plus a rising-edge detector.
// Produces at most one single-cycle pulse per clock.
module ro_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic osc_i,
    output logic rise_o
);

    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [SYNC_STAGES-1:0] sync_q;
    logic prev_q;

    // Synchroniser chain and previous-sample flop for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enables the RO, warms it up, counts synchronised
// rising edges over a fixed gate window and returns a saturating count via valid/ready.
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int CNT_WIDTH     = 24,
    parameter int GATE_CYCLES   = 1000,
    parameter int WARMUP_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iStart,
    input  logic                 iOsc,
    output logic                 oRoEn,
    output logic                 oBusy,
    output logic [CNT_WIDTH-1:0] oCount,
    output logic                 oOverflow,
    output logic                 oValid,
    input  logic                 iReady
);

    localparam int                   TW        = tmr_width(GATE_CYCLES, WARMUP_CYCLES);
    localparam logic [TW-1:0]        WARM_LOAD = TW'(WARMUP_CYCLES - 1);
    localparam logic [TW-1:0]        GATE_LOAD = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    state_e                 state_q, state_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   roen_q, busy_q, valid_q;
    logic                   rise_s;

    ro_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (iClk),
        .rst_ni (iRst_n),
        .osc_i  (iOsc),
        .rise_o (rise_s)
    );

    // Next-state, timer, edge counter and result capture.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_WARMUP;
                    tmr_d   = WARM_LOAD;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (tmr_q == '0) begin
                    state_d = ST_GATE;
                    tmr_d   = GATE_LOAD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_GATE: begin
                // A pulse arriving at all-ones is dropped and recorded as overflow.
                if (rise_s) begin
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                if (tmr_q == '0) begin
                    state_d = ST_HOLD;
                    count_d = cnt_d;
                    ovf_d   = sat_d;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_HOLD: begin
                if (iReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output decodes.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            roen_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            roen_q  <= (state_d == ST_WARMUP) || (state_d == ST_GATE);
            busy_q  <= (state_d != ST_IDLE);
            valid_q <= (state_d == ST_HOLD);
        end
    end

    assign oRoEn     = roen_q;
    assign oBusy     = busy_q;
    assign oValid    = valid_q;
    assign oCount    = count_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed self-checking bench for ro_freq_counter (GATE=100, WARMUP=8, SYNC=2),
// with a second 4-bit instance for saturation.
`timescale 1ns/1ps
module tb_ro_freq_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        osc = 1'b0;
    logic        start = 1'b0, ready = 1'b0;
    logic        roen, busy, valid, ovf;
    logic [23:0] count;
    logic        start4 = 1'b0, ready4 = 1'b0;
    logic        roen4, busy4, valid4, ovf4;
    logic [3:0]  count4;

    int n_vec = 0;
    int n_err = 0;
    int osc_half = 50;
    int osc_mode = 0;

    ro_freq_counter #(.CNT_WIDTH(24), .GATE_CYCLES(100), .WARMUP_CYCLES(8), .SYNC_STAGES(2)) dut (
        .iClk(clk), .iRst_n(rst_n), .iStart(start), .iOsc(osc), .oRoEn(roen), .oBusy(busy),
        .oCount(count), .oOverflow(ovf), .oValid(valid), .iReady(ready));

    ro_freq_counter #(.CNT_WIDTH(4), .GATE_CYCLES(100), .WARMUP_CYCLES(8), .SYNC_STAGES(2)) dut4 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start4), .iOsc(osc), .oRoEn(roen4), .oBusy(busy4),
        .oCount(count4), .oOverflow(ovf4), .oValid(valid4), .iReady(ready4));

    always #5 clk = ~clk;

    // RO model: square wave offset 3 ns from clock edges, or stuck at 0 / 1.
    initial begin
        #3;
        forever begin
            if (osc_mode == 0) begin
                #(osc_half);
                osc = ~osc;
            end else begin
                osc = (osc_mode == 2);
                #10;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit sel, output int e);
        if (sel) start4 = 1'b1; else start = 1'b1;
        tick();
        start  = 1'b0;
        start4 = 1'b0;
        e = 0;
        while (((sel ? valid4 : valid) == 1'b0) && e < 400) begin
            tick();
            e = e + 1;
        end
        chk(sel ? "run4_latency" : "run_latency", e, 108);
    endtask

    task automatic ack(input bit sel);
        if (sel) ready4 = 1'b1; else ready = 1'b1;
        tick();
        ready  = 1'b0;
        ready4 = 1'b0;
        chk("ack_valid_drop", sel ? int'(valid4) : int'(valid), 0);
        chk("ack_busy_drop", sel ? int'(busy4) : int'(busy), 0);
    endtask

    initial begin
        int e;
        int roen_hi;
        int stable;
        int saved;
        int low_n;
        int low_idx[2];
        int vcnt;

        // Reset state
        #2;
        chk("rst_roen", int'(roen), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_count", int'(count), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: period 10 clk, latency and enable window
        osc_mode = 0;
        osc_half = 50;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_roen_rise", int'(roen), 1);
        chk("t1_busy_rise", int'(busy), 1);
        e = 0;
        roen_hi = 1;
        while (!valid && e < 400) begin
            tick();
            e = e + 1;
            if (roen) roen_hi = roen_hi + 1;
        end
        chk("t1_latency", e, 108);
        chk("t1_roen_cycles", roen_hi, 108);
        chk("t1_count_range", int'(count >= 24'd9 && count <= 24'd11), 1);
        chk("t1_ovf", int'(ovf), 0);
        ack(1'b0);

        // 2: 4-bit saturation then a non-saturating run
        osc_half = 20;
        run(1'b1, e);
        chk("t2_sat_count", int'(count4), 15);
        chk("t2_sat_ovf", int'(ovf4), 1);
        ack(1'b1);
        osc_half = 100;
        run(1'b1, e);
        chk("t2_count5", int'(count4), 5);
        chk("t2_ovf_clear", int'(ovf4), 0);
        ack(1'b1);

        // 4: stuck-0 then stuck-1 from before start
        osc_mode = 1;
        run(1'b0, e);
        chk("t4_stuck0_count", int'(count), 0);
        chk("t4_stuck0_ovf", int'(ovf), 0);
        ack(1'b0);
        osc_mode = 2;
        repeat (4) tick();
        run(1'b0, e);
        chk("t4_stuck1_count", int'(count), 0);
        chk("t4_stuck1_ovf", int'(ovf), 0);
        ack(1'b0);

        // 3: HOLD backpressure with repeated start requests
        osc_mode = 0;
        osc_half = 50;
        run(1'b0, e);
        chk("t3_count_range", int'(count >= 24'd9 && count <= 24'd11), 1);
        saved = int'(count);
        stable = 0;
        for (int i = 0; i < 30; i++) begin
            start = (i % 2 == 0);
            tick();
            if (valid && busy && !roen && int'(count) == saved) stable = stable + 1;
        end
        chk("t3_hold_stable", stable, 30);
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b0;
        chk("t3_handshake_valid", int'(valid), 0);
        chk("t3_start_ignored", int'(busy), 0);
        tick();
        chk("t3_stays_idle", int'(busy), 0);
        chk("t3_count_kept", int'(count), saved);

        // 5: async reset in the middle of the gate
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (58) tick();
        chk("t5_pre_roen", int'(roen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_roen", int'(roen), 0);
        chk("t5_async_busy", int'(busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_idle_busy", int'(busy), 0);
        chk("t5_count_zero", int'(count), 0);
        chk("t5_valid_zero", int'(valid), 0);
        run(1'b0, e);
        chk("t5_fresh_count", int'(count >= 24'd9 && count <= 24'd11), 1);
        chk("t5_fresh_ovf", int'(ovf), 0);
        ack(1'b0);

        // 6: continuous start with ready high gives back-to-back runs
        start = 1'b1;
        ready = 1'b1;
        low_n = 0;
        vcnt = 0;
        low_idx[0] = -1;
        low_idx[1] = -1;
        for (int s = 0; s < 220; s++) begin
            tick();
            if (valid) vcnt = vcnt + 1;
            if (!busy) begin
                if (low_n < 2) low_idx[low_n] = s;
                low_n = low_n + 1;
            end
        end
        start = 1'b0;
        ready = 1'b0;
        chk("t6_idle_count", low_n, 2);
        chk("t6_idle_first", low_idx[0], 109);
        chk("t6_idle_second", low_idx[1], 219);
        chk("t6_valid_cycles", vcnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
